// File: rtl/avmm_arb_pkg.sv
// Shared types and widths for the Avalon-MM read/write arbiter (avmm_rw_arbiter).
// Widths are sized for the largest legal configuration (8 requesters, 16 pending reads).
package avmm_arb_pkg;

    localparam int MAX_NUM_REQ  = 8;
    localparam int MAX_PEND_LIM = 16;
    localparam int ID_W         = $clog2(MAX_NUM_REQ);
    localparam int PEND_W       = $clog2(MAX_PEND_LIM) + 1;

    typedef logic [ID_W-1:0] req_id_t;

    // Round-robin successor of a requester id among n requesters.
    function automatic req_id_t next_id(input req_id_t id, input int n);
        if (int'(id) == n - 1) begin
            return '0;
        end
        return id + 1'b1;
    endfunction

endpackage

// File: rtl/avmm_arb_tag_fifo.sv
// In-order FIFO of requester ids for outstanding reads; head is the owner of the next return.
// Asynchronous active-low reset empties the queue; stored ids are not cleared.
module avmm_arb_tag_fifo
    import avmm_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              push,
    input  req_id_t           push_id,
    input  logic              pop,
    output req_id_t           head,
    output logic [PEND_W-1:0] count,
    output logic              full,
    output logic              empty
);

    localparam int PTR_W = $clog2(DEPTH);

    req_id_t           mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_reg;
    logic [PTR_W-1:0]  rd_ptr_reg;
    logic [PEND_W-1:0] count_reg;
    logic              do_push;
    logic              do_pop;

    assign full    = (count_reg == PEND_W'(DEPTH));
    assign empty   = (count_reg == '0);
    assign count   = count_reg;
    assign head    = mem[rd_ptr_reg];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= push_id;
        end
    end

    // DEPTH is a power of two, so the pointers wrap on their own.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + 1'b1;
                2'b01:   count_reg <= count_reg - 1'b1;
                default: count_reg <= count_reg;
            endcase
        end
    end

endmodule

// File: rtl/avmm_rw_arbiter.sv
// Round-robin arbiter sharing one Avalon-MM read/write master among NUM_REQ requesters.
// Optional feature macro AVMM_ARB_LOCK_EN adds req_lock for exclusive ownership.
module avmm_rw_arbiter
    import avmm_arb_pkg::*;
#(
    parameter int NUM_REQ  = 2,
    parameter int ADDR_W   = 64,
    parameter int DATA_W   = 64,
    parameter int MAX_PEND = 4
) (
    input  logic                         clock,
    input  logic                         resetn,
    input  logic [NUM_REQ*ADDR_W-1:0]    req_address,
    input  logic [NUM_REQ*DATA_W/8-1:0]  req_byteenable,
    input  logic [NUM_REQ-1:0]           req_read,
    input  logic [NUM_REQ-1:0]           req_write,
    input  logic [NUM_REQ*DATA_W-1:0]    req_writedata,
`ifdef AVMM_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]           req_lock,
`endif
    output logic [NUM_REQ-1:0]           req_waitrequest,
    output logic [DATA_W-1:0]            req_readdata,
    output logic [NUM_REQ-1:0]           req_readdatavalid,
    output logic [ADDR_W-1:0]            avm_address,
    output logic [DATA_W/8-1:0]          avm_byteenable,
    output logic                         avm_read,
    output logic                         avm_write,
    output logic [DATA_W-1:0]            avm_writedata,
    input  logic                         avm_waitrequest,
    input  logic [DATA_W-1:0]            avm_readdata,
    input  logic                         avm_readdatavalid
);

    localparam int BE_W = DATA_W / 8;

    req_id_t                rr_ptr_reg;
    req_id_t                grant_id;
    req_id_t                fifo_head;
    logic [NUM_REQ-1:0]     eligible_raw;
    logic [NUM_REQ-1:0]     eligible;
    logic [NUM_REQ-1:0]     grant_oh;
    logic [2*NUM_REQ-1:0]   rotated;
    logic                   grant_found;
    logic                   grant_is_read;
    logic                   accept;
    logic                   read_ok;
    logic                   push;
    logic                   pop;
    logic                   fifo_full;
    logic                   fifo_empty;
    logic [PEND_W-1:0]      pend_cnt;
    logic                   rdv_reg;
    logic [DATA_W-1:0]      rdata_reg;

    assign read_ok = (pend_cnt < PEND_W'(MAX_PEND));

    // Reads win over writes when both are raised; a read blocked by a full tag queue is skipped.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign eligible_raw[gi]      = req_read[gi] ? read_ok : req_write[gi];
            assign grant_oh[gi]          = grant_found & (grant_id == req_id_t'(gi));
            assign req_readdatavalid[gi] = pop & (fifo_head == req_id_t'(gi));
        end
    endgenerate

`ifdef AVMM_ARB_LOCK_EN
    req_id_t            owner_reg;
    logic               owner_valid_reg;
    logic [NUM_REQ-1:0] owner_oh;
    logic               locked;

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_owner
            assign owner_oh[gi] = (owner_reg == req_id_t'(gi));
        end
    endgenerate

    // The last accepted requester keeps exclusive grant while it holds its lock, even when idle.
    assign locked   = owner_valid_reg & |(owner_oh & req_lock);
    assign eligible = locked ? (eligible_raw & owner_oh) : eligible_raw;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            owner_reg       <= '0;
            owner_valid_reg <= 1'b0;
        end else if (accept) begin
            owner_reg       <= grant_id;
            owner_valid_reg <= 1'b1;
        end
    end
`else
    assign eligible = eligible_raw;
`endif

    // Rotate so bit 0 is the requester at rr_ptr, then take the first set bit.
    assign rotated = {eligible, eligible} >> rr_ptr_reg;

    always_comb begin
        int sum;
        grant_found = 1'b0;
        grant_id    = '0;
        sum         = 0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && rotated[k]) begin
                grant_found = 1'b1;
                sum         = int'(rr_ptr_reg) + k;
                if (sum >= NUM_REQ) begin
                    sum = sum - NUM_REQ;
                end
                grant_id = req_id_t'(sum);
            end
        end
    end

    always_comb begin
        avm_address    = '0;
        avm_byteenable = '0;
        avm_writedata  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (grant_oh[i]) begin
                avm_address    = req_address[i*ADDR_W +: ADDR_W];
                avm_byteenable = req_byteenable[i*BE_W +: BE_W];
                avm_writedata  = req_writedata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign grant_is_read   = |(grant_oh & req_read);
    assign avm_read        = resetn & grant_found & grant_is_read;
    assign avm_write       = resetn & grant_found & ~grant_is_read;
    assign accept          = resetn & grant_found & ~avm_waitrequest;
    assign req_waitrequest = ~(grant_oh & {NUM_REQ{accept}});
    assign push            = accept & grant_is_read & ~fifo_full;
    assign pop             = rdv_reg & ~fifo_empty;
    assign req_readdata    = rdata_reg;

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rr_ptr_reg <= '0;
            rdv_reg    <= 1'b0;
            rdata_reg  <= '0;
        end else begin
            if (accept) begin
                rr_ptr_reg <= next_id(grant_id, NUM_REQ);
            end
            rdv_reg <= avm_readdatavalid;
            if (avm_readdatavalid) begin
                rdata_reg <= avm_readdata;
            end
        end
    end

    avmm_arb_tag_fifo #(
        .DEPTH (MAX_PEND)
    ) u_tag_fifo (
        .clock   (clock),
        .resetn  (resetn),
        .push    (push),
        .push_id (grant_id),
        .pop     (pop),
        .head    (fifo_head),
        .count   (pend_cnt),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

endmodule

// File: tb/tb_avmm_rw_arbiter.sv
// Self-checking bench for avmm_rw_arbiter: directed scenarios plus a randomized phase,
// compared each cycle against a queue-based reference model of the arbitration rules.
module tb_avmm_rw_arbiter;

    localparam int N  = 2;
    localparam int AW = 64;
    localparam int DW = 64;
    localparam int BW = DW / 8;
    localparam int MP = 4;

    logic              clock = 1'b0;
    logic              resetn;
    logic [N*AW-1:0]   req_address;
    logic [N*BW-1:0]   req_byteenable;
    logic [N-1:0]      req_read;
    logic [N-1:0]      req_write;
    logic [N*DW-1:0]   req_writedata;
`ifdef AVMM_ARB_LOCK_EN
    logic [N-1:0]      req_lock;
`endif
    logic [N-1:0]      req_waitrequest;
    logic [DW-1:0]     req_readdata;
    logic [N-1:0]      req_readdatavalid;
    logic [AW-1:0]     avm_address;
    logic [BW-1:0]     avm_byteenable;
    logic              avm_read;
    logic              avm_write;
    logic [DW-1:0]     avm_writedata;
    logic              avm_waitrequest;
    logic [DW-1:0]     avm_readdata;
    logic              avm_readdatavalid;

    int checks = 0;
    int errors = 0;

    // Reference model state
    int          rr;
    int          pend_q[$];
    bit          ret_flag;
    logic [63:0] ret_data;
    int          ds_out;
    int          owner;
    logic [N-1:0] acc_oh;

    always #5 clock = ~clock;

    avmm_rw_arbiter #(
        .NUM_REQ  (N),
        .ADDR_W   (AW),
        .DATA_W   (DW),
        .MAX_PEND (MP)
    ) dut (
        .clock             (clock),
        .resetn            (resetn),
        .req_address       (req_address),
        .req_byteenable    (req_byteenable),
        .req_read          (req_read),
        .req_write         (req_write),
        .req_writedata     (req_writedata),
`ifdef AVMM_ARB_LOCK_EN
        .req_lock          (req_lock),
`endif
        .req_waitrequest   (req_waitrequest),
        .req_readdata      (req_readdata),
        .req_readdatavalid (req_readdatavalid),
        .avm_address       (avm_address),
        .avm_byteenable    (avm_byteenable),
        .avm_read          (avm_read),
        .avm_write         (avm_write),
        .avm_writedata     (avm_writedata),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_cmd(input int i, input bit rd, input bit wr,
                           input logic [63:0] a, input logic [63:0] d);
        req_read[i]  = rd;
        req_write[i] = wr;
        req_address[i*AW +: AW]    = a;
        req_writedata[i*DW +: DW]  = d;
        req_byteenable[i*BW +: BW] = BW'($urandom);
    endtask

    task automatic clear_cmds();
        for (int i = 0; i < N; i++) set_cmd(i, 1'b0, 1'b0, 64'h0, 64'h0);
    endtask

    function automatic bit elig(input int i);
        return (req_read[i] && pend_q.size() < MP) || (!req_read[i] && req_write[i]);
    endfunction

    // One clock cycle: evaluate the model, compare at the falling edge, then advance the model.
    task automatic step();
        int g;
        bit found;
        bit acc;
        bit is_rd;
        logic [N-1:0] exp_wr;
        logic [N-1:0] exp_rdv;
        @(negedge clock);
        found = 1'b0;
        g = 0;
`ifdef AVMM_ARB_LOCK_EN
        if (owner >= 0 && req_lock[owner]) begin
            found = elig(owner);
            g = owner;
        end else
`endif
        for (int k = 0; k < N; k++) begin
            if (!found && elig((rr + k) % N)) begin
                found = 1'b1;
                g = (rr + k) % N;
            end
        end
        is_rd  = found && req_read[g];
        acc    = found && !avm_waitrequest;
        exp_wr = '1;
        if (acc) exp_wr[g] = 1'b0;
        chk("waitrequest", 64'(req_waitrequest), 64'(exp_wr));
        chk("avm_read", 64'(avm_read), 64'(is_rd));
        chk("avm_write", 64'(avm_write), 64'(found && !is_rd));
        if (found) begin
            chk("avm_address", avm_address, req_address[g*AW +: AW]);
            chk("avm_byteenable", 64'(avm_byteenable), 64'(req_byteenable[g*BW +: BW]));
            if (!is_rd) chk("avm_writedata", avm_writedata, req_writedata[g*DW +: DW]);
        end
        exp_rdv = '0;
        if (ret_flag && pend_q.size() > 0) exp_rdv[pend_q[0]] = 1'b1;
        chk("readdatavalid", 64'(req_readdatavalid), 64'(exp_rdv));
        if (exp_rdv != '0) begin
            chk("readdata", req_readdata, ret_data);
            void'(pend_q.pop_front());
        end
        acc_oh = ~exp_wr;
        if (acc) begin
            rr = (g + 1) % N;
            owner = g;
            if (is_rd) begin
                pend_q.push_back(g);
                ds_out++;
            end
        end
        ret_flag = avm_readdatavalid;
        ret_data = avm_readdata;
        if (avm_readdatavalid && ds_out > 0) ds_out--;
        @(posedge clock);
        #1;
    endtask

    task automatic do_reset(input int cycles);
        resetn = 1'b0;
        avm_readdatavalid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clock);
            chk("rst_avm_read", 64'(avm_read), 64'h0);
            chk("rst_avm_write", 64'(avm_write), 64'h0);
            chk("rst_waitrequest", 64'(req_waitrequest), 64'({N{1'b1}}));
            chk("rst_readdatavalid", 64'(req_readdatavalid), 64'h0);
            chk("rst_readdata", req_readdata, 64'h0);
            @(posedge clock);
            #1;
        end
        resetn = 1'b1;
        rr = 0;
        pend_q.delete();
        ret_flag = 1'b0;
        ret_data = '0;
        ds_out = 0;
        owner = -1;
    endtask

    // Return every outstanding read in order with fresh random data.
    task automatic drain();
        clear_cmds();
        avm_waitrequest = 1'b0;
        for (int k = 0; k < MP + 3; k++) begin
            avm_readdatavalid = (ds_out > 0);
            avm_readdata = {$urandom, $urandom};
            step();
        end
        avm_readdatavalid = 1'b0;
        step();
    endtask

    initial begin
        int kind;
        resetn = 1'b0;
        req_read = '0;
        req_write = '0;
        req_address = '0;
        req_writedata = '0;
        req_byteenable = '0;
`ifdef AVMM_ARB_LOCK_EN
        req_lock = '0;
`endif
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        avm_readdatavalid = 1'b0;
        acc_oh = '0;

        // Reset with requests active: outputs must stay gated
        set_cmd(0, 1'b1, 1'b0, 64'h40, 64'h0);
        set_cmd(1, 1'b0, 1'b1, 64'h80, 64'h55);
        do_reset(3);

        // Single read from requester 0, data returned two cycles later
        clear_cmds();
        set_cmd(0, 1'b1, 1'b0, 64'h1000, 64'h0);
        step();
        clear_cmds();
        step();
        avm_readdatavalid = 1'b1;
        avm_readdata = 64'hDEAD_BEEF;
        step();
        avm_readdatavalid = 1'b0;
        step();

        // Both requesters write every cycle with no stall
        for (int c = 0; c < 6; c++) begin
            set_cmd(0, 1'b0, 1'b1, 64'h2000 + 64'(c), {$urandom, $urandom});
            set_cmd(1, 1'b0, 1'b1, 64'h3000 + 64'(c), {$urandom, $urandom});
            step();
        end

        // Requester 1 read under a 3-cycle downstream stall
        clear_cmds();
        set_cmd(1, 1'b1, 1'b0, 64'h4444, 64'h0);
        avm_waitrequest = 1'b1;
        for (int c = 0; c < 3; c++) step();
        avm_waitrequest = 1'b0;
        step();
        drain();

        // Outstanding-read limit: fifth read held while a write still gets through
        set_cmd(0, 1'b1, 1'b0, 64'h5000, 64'h0);
        for (int c = 0; c < MP; c++) step();
        set_cmd(1, 1'b0, 1'b1, 64'h6000, 64'h1234);
        step();
        set_cmd(1, 1'b0, 1'b0, 64'h0, 64'h0);
        step();
        avm_readdatavalid = 1'b1;
        avm_readdata = 64'hA5A5;
        step();
        avm_readdatavalid = 1'b0;
        step();
        step();
        drain();

        // Interleaved reads 1,0,1 with in-order returns A,B,C
        clear_cmds();
        set_cmd(1, 1'b1, 1'b0, 64'h7001, 64'h0);
        step();
        clear_cmds();
        set_cmd(0, 1'b1, 1'b0, 64'h7000, 64'h0);
        step();
        clear_cmds();
        set_cmd(1, 1'b1, 1'b0, 64'h7002, 64'h0);
        step();
        clear_cmds();
        avm_readdatavalid = 1'b1;
        avm_readdata = 64'hAAAA;
        step();
        avm_readdata = 64'hBBBB;
        step();
        avm_readdata = 64'hCCCC;
        step();
        avm_readdatavalid = 1'b0;
        step();

`ifdef AVMM_ARB_LOCK_EN
        // Requester 1 locks while requester 0 keeps requesting
        drain();
        set_cmd(0, 1'b0, 1'b1, 64'h8000, 64'h1);
        set_cmd(1, 1'b0, 1'b1, 64'h9000, 64'h2);
        req_lock = 2'b10;
        for (int c = 0; c < 6; c++) step();
        req_lock = '0;
        for (int c = 0; c < 3; c++) step();
`endif

        // Randomized traffic with stalls, returns and a mid-run reset
        clear_cmds();
        acc_oh = '1;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (acc_oh[i] || !(req_read[i] || req_write[i])) begin
                    kind = $urandom_range(0, 9);
                    set_cmd(i, kind >= 3 && kind <= 5 || kind == 9, kind >= 6,
                            {$urandom, $urandom}, {$urandom, $urandom});
                end
            end
            avm_waitrequest = ($urandom_range(0, 3) == 0);
            avm_readdatavalid = (ds_out > 0) && ($urandom_range(0, 2) != 0);
            avm_readdata = {$urandom, $urandom};
`ifdef AVMM_ARB_LOCK_EN
            req_lock = ($urandom_range(0, 4) == 0) ? N'($urandom) : '0;
`endif
            step();
            if (c == 200) begin
                do_reset(2);
                clear_cmds();
                avm_waitrequest = 1'b0;
                avm_readdatavalid = 1'b1;
                avm_readdata = 64'hBAD0;
                step();
                avm_readdatavalid = 1'b0;
                step();
                acc_oh = '1;
            end
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
